// File: rtl/bts_st_packet_arbiter.sv
// bts_st_packet_arbiter
//   Packet-granular round-robin arbiter merging NUM_IN Avalon-ST byte sources
//   onto one registered output stream (readyLatency 0 on both sides).
//   A source keeps the grant from its first accepted beat through its eop beat.
//   Every beat is tagged with the index of its source.
// Ports
//   clk, reset   rising-edge clock, asynchronous active-high reset
//   in_valid     per-source beat valid            [NUM_IN]
//   in_data      source i at [i*DATA_W +: DATA_W] [NUM_IN*DATA_W]
//   in_sop       per-source start of packet       [NUM_IN]
//   in_eop       per-source end of packet         [NUM_IN]
//   in_ready     per-source ready, combinational  [NUM_IN]
//   out_valid    registered beat valid
//   out_data     registered beat data             [DATA_W]
//   out_sop      registered start of packet
//   out_eop      registered end of packet
//   out_channel  source index of the held beat    [CHAN_W]
//   out_ready    downstream ready
//   pkt_count    saturating count of forwarded eop beats [16]
module bts_st_packet_arbiter #(
  parameter int unsigned NUM_IN = 2,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CHAN_W = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_IN-1:0]          in_valid,
  input  logic [NUM_IN*DATA_W-1:0]   in_data,
  input  logic [NUM_IN-1:0]          in_sop,
  input  logic [NUM_IN-1:0]          in_eop,
  output logic [NUM_IN-1:0]          in_ready,
  output logic                       out_valid,
  output logic [DATA_W-1:0]          out_data,
  output logic                       out_sop,
  output logic                       out_eop,
  output logic [CHAN_W-1:0]          out_channel,
  input  logic                       out_ready,
  output logic [15:0]                pkt_count
);

  localparam int unsigned IDX_W = $clog2(NUM_IN);
  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]   last_grant_q, last_grant_d;
  logic [IDX_W-1:0]   rr_idx, cand;
  logic               rr_found;
  logic               load_c;
  logic               xfer_c;
  logic               eop_xfer_c;
  logic [CNT_W-1:0]   pkt_count_d;
  logic [DATA_W-1:0]  src_data [NUM_IN];

  // Unpack the flat data bus into per-source beats.
  for (genvar i = 0; i < NUM_IN; i++) begin : g_unpack
    assign src_data[i] = in_data[i*DATA_W +: DATA_W];
  end

  // Output register can take a beat when empty or being drained this cycle.
  assign load_c = !out_valid || out_ready;

  // Round-robin pick: first valid source after last_grant, wrapping.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = last_grant_q;
    cand     = '0;
    for (int unsigned k = 1; k <= NUM_IN; k++) begin
      cand = IDX_W'((32'(last_grant_q) + k) % NUM_IN);
      if (!rr_found && in_valid[cand]) begin
        rr_found = 1'b1;
        rr_idx   = cand;
      end
    end
  end

  // Next-state and handshake decode.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    in_ready     = '0;
    xfer_c       = 1'b0;
    eop_xfer_c   = 1'b0;
    case (state_q)
      IDLE: begin
        if (|in_valid) begin
          grant_d = rr_idx;
          state_d = LOCKED;
        end
      end
      LOCKED: begin
        in_ready[grant_q] = load_c;
        xfer_c            = in_valid[grant_q] && load_c;
        eop_xfer_c        = xfer_c && in_eop[grant_q];
        if (eop_xfer_c) begin
          last_grant_d = grant_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Saturating packet counter next value.
  always_comb begin
    pkt_count_d = pkt_count;
    if (eop_xfer_c && (pkt_count != CNT_MAX)) begin
      pkt_count_d = pkt_count + CNT_W'(1);
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= IDX_W'(NUM_IN - 1);
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Output stage; holds while downstream stalls, a held beat is lost on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_sop     <= 1'b0;
      out_eop     <= 1'b0;
      out_channel <= '0;
      pkt_count   <= '0;
    end else begin
      pkt_count <= pkt_count_d;
      if (load_c) begin
        out_valid <= xfer_c;
        if (xfer_c) begin
          out_data    <= src_data[grant_q];
          out_sop     <= in_sop[grant_q];
          out_eop     <= in_eop[grant_q];
          out_channel <= CHAN_W'(grant_q);
        end
      end
    end
  end

endmodule
